// File: rtl/stream_demux_pkg.sv
// -----------------------------------------------------------------------------
// stream_demux_pkg
// Shared definitions for the registered 1-to-N stream demultiplexer:
//   - default parameter constants
//   - slot state type (EMPTY / FULL)
//   - saturating increment helper used by the drop counter
// -----------------------------------------------------------------------------
package stream_demux_pkg;

  localparam int DEF_DATA_W  = 8;
  localparam int DEF_NUM_OUT = 8;
  localparam int DEF_CNT_W   = 8;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  // Increment v by one, holding at maxv instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v,
                                          input logic [31:0] maxv);
    logic [31:0] r;
    if (v >= maxv) r = maxv;
    else           r = v + 32'd1;
    return r;
  endfunction

endpackage : stream_demux_pkg

// File: rtl/stream_demux_slot.sv
// -----------------------------------------------------------------------------
// stream_demux_slot
// One-entry register slot with valid/ready handshake on the output side.
// A full slot that is being drained this cycle counts as free, so a load and a
// drain may happen on the same edge (data replaced, slot stays full).
//
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   i_load   in   write i_data into the slot on this edge
//   i_data   in   DATA_W payload to load
//   i_ready  in   consumer ready for this slot
//   o_free   out  slot can take a load this cycle (combinational)
//   o_valid  out  slot holds a word
//   o_data   out  DATA_W stored payload (last value kept while empty)
// -----------------------------------------------------------------------------
module stream_demux_slot
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_ready,
  output logic              o_free,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  slot_state_e       r_state;
  slot_state_e       w_state_nxt;
  logic [DATA_W-1:0] r_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SLOT_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      SLOT_EMPTY: if (i_load) w_state_nxt = SLOT_FULL;
      SLOT_FULL: begin
        if (i_load)       w_state_nxt = SLOT_FULL;
        else if (i_ready) w_state_nxt = SLOT_EMPTY;
      end
      default: w_state_nxt = SLOT_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (i_load) begin
      r_data <= i_data;
    end
  end

  assign o_valid = (r_state == SLOT_FULL);
  assign o_free  = (r_state == SLOT_EMPTY) || i_ready;
  assign o_data  = r_data;

endmodule : stream_demux_slot

// File: rtl/stream_demux_reg.sv
// -----------------------------------------------------------------------------
// stream_demux_reg
// Registered 1-to-NUM_OUT stream demultiplexer. Each output channel owns a
// one-entry slot, so a stalled consumer only blocks words addressed to it.
// Words with in_sel >= NUM_OUT are accepted, discarded and counted in a
// saturating drop counter.
//
// Optional feature (macro STREAM_DEMUX_BCAST_EN): adds in_bcast; a broadcast
// word waits until every slot is free and then loads all slots at once.
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   input word valid
//   in_ready   out  input word can be accepted (combinational, not on in_valid)
//   in_sel     in   SEL_W destination channel
//   in_data    in   DATA_W payload
//   in_bcast   in   broadcast request (only with STREAM_DEMUX_BCAST_EN)
//   out_valid  out  NUM_OUT per-channel slot full
//   out_ready  in   NUM_OUT per-channel consumer ready
//   out_data   out  NUM_OUT*DATA_W, channel k at [k*DATA_W +: DATA_W]
//   drop_cnt   out  CNT_W saturating count of dropped words
// -----------------------------------------------------------------------------
module stream_demux_reg
  import stream_demux_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int SEL_W   = $clog2(NUM_OUT),
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [SEL_W-1:0]          in_sel,
  input  logic [DATA_W-1:0]         in_data,
`ifdef STREAM_DEMUX_BCAST_EN
  input  logic                      in_bcast,
`endif
  output logic [NUM_OUT-1:0]        out_valid,
  input  logic [NUM_OUT-1:0]        out_ready,
  output logic [NUM_OUT*DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]          drop_cnt
);

  logic [NUM_OUT-1:0] w_free;
  logic [NUM_OUT-1:0] w_load;
  logic [NUM_OUT-1:0] w_uni_load;
  logic               w_uni_ready;
  logic               w_uni_drop;
  logic               w_sel_ok;
  logic               w_drop;
  logic [CNT_W-1:0]   r_drop_cnt;

  assign w_sel_ok = (32'(in_sel) < NUM_OUT);

  // Unicast decode. Loop compare instead of indexing keeps out-of-range
  // selects (non power-of-two NUM_OUT) from touching any slot.
  always_comb begin
    w_uni_load  = '0;
    w_uni_ready = 1'b0;
    w_uni_drop  = 1'b0;
    if (!w_sel_ok) begin
      w_uni_ready = 1'b1;
      w_uni_drop  = in_valid;
    end else begin
      for (int k = 0; k < NUM_OUT; k++) begin
        if (in_sel == SEL_W'(k)) begin
          w_uni_ready   = w_free[k];
          w_uni_load[k] = in_valid && w_free[k];
        end
      end
    end
  end

`ifdef STREAM_DEMUX_BCAST_EN
  // Broadcast needs every slot free; in_sel and the drop counter are ignored.
  always_comb begin
    w_load   = w_uni_load;
    in_ready = w_uni_ready;
    w_drop   = w_uni_drop;
    if (in_bcast) begin
      in_ready = &w_free;
      w_drop   = 1'b0;
      w_load   = (in_valid && (&w_free)) ? {NUM_OUT{1'b1}} : '0;
    end
  end
`else
  assign w_load   = w_uni_load;
  assign in_ready = w_uni_ready;
  assign w_drop   = w_uni_drop;
`endif

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    stream_demux_slot #(
      .DATA_W (DATA_W)
    ) u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_load  (w_load[k]),
      .i_data  (in_data),
      .i_ready (out_ready[k]),
      .o_free  (w_free[k]),
      .o_valid (out_valid[k]),
      .o_data  (out_data[k*DATA_W +: DATA_W])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_drop_cnt <= CNT_W'(sat_inc(32'(r_drop_cnt), 32'({CNT_W{1'b1}})));
    end
  end

  assign drop_cnt = r_drop_cnt;

endmodule : stream_demux_reg

// File: tb/tb_stream_demux_reg.sv
module tb_stream_demux_reg;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        valid = 1'b0;
  logic        ready;
  logic [2:0]  sel = '0;
  logic [7:0]  data = '0;
  logic        bcast = 1'b0;
  logic [7:0]  ovalid;
  logic [7:0]  oready = '1;
  logic [63:0] odata;
  logic [7:0]  drop;

  logic        valid2 = 1'b0;
  logic        ready2;
  logic [2:0]  sel2 = '0;
  logic [7:0]  data2 = '0;
  logic [5:0]  ovalid2;
  logic [47:0] odata2;
  logic [1:0]  drop2;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q [8][$];

  always #5 clk = ~clk;

  stream_demux_reg #(.DATA_W(8), .NUM_OUT(8), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (valid),
    .in_ready  (ready),
    .in_sel    (sel),
    .in_data   (data),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast  (bcast),
`endif
    .out_valid (ovalid),
    .out_ready (oready),
    .out_data  (odata),
    .drop_cnt  (drop)
  );

  stream_demux_reg #(.DATA_W(8), .NUM_OUT(6), .CNT_W(2)) dut2 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (valid2),
    .in_ready  (ready2),
    .in_sel    (sel2),
    .in_data   (data2),
`ifdef STREAM_DEMUX_BCAST_EN
    .in_bcast  (1'b0),
`endif
    .out_valid (ovalid2),
    .out_ready (6'h3f),
    .out_data  (odata2),
    .drop_cnt  (drop2)
  );

  // One clock with scoreboard bookkeeping. Called just after a negedge with
  // inputs already driven: consumer handshakes pop and compare, input
  // transfers push expectations, then advance to the next negedge.
  task automatic cycle();
    logic [7:0] e;
    #1;
    for (int k = 0; k < 8; k++) begin
      if (ovalid[k] && oready[k]) begin
        total++;
        if (exp_q[k].size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected ch%0d: got 0x%02h, required no word", k, odata[k*8 +: 8]);
        end else begin
          e = exp_q[k].pop_front();
          if (odata[k*8 +: 8] !== e) begin
            bad++;
            $display("FAIL sb_data ch%0d: got 0x%02h, required 0x%02h", k, odata[k*8 +: 8], e);
          end
        end
      end
    end
    if (valid && ready) begin
      if (bcast) begin
        for (int k = 0; k < 8; k++) exp_q[k].push_back(data);
      end else begin
        exp_q[sel].push_back(data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_sb();
    for (int k = 0; k < 8; k++) exp_q[k].delete();
  endtask

  task automatic test_reset();
    #1;
    total++;
    if (ovalid !== 8'h00 || odata !== 64'h0 || drop !== 8'h00) begin
      bad++;
      $display("FAIL reset_state: ovalid=%h odata=%h drop=%h, required 0/0/0", ovalid, odata, drop);
    end
    total++;
    if (ovalid2 !== 6'h00 || drop2 !== 2'd0) begin
      bad++;
      $display("FAIL reset_state2: ovalid=%h drop=%h, required 0/0", ovalid2, drop2);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_routing();
    oready = 8'hff;
    for (int s = 0; s < 8; s++) begin
      valid = 1'b1;
      sel   = 3'(s);
      data  = 8'hA0 + 8'(s);
      #1;
      total++;
      if (ready !== 1'b1) begin
        bad++;
        $display("FAIL route_ready sel=%0d: got %b, required 1", s, ready);
      end
      cycle();
      total++;
      if (ovalid !== (8'h01 << s) || odata[s*8 +: 8] !== (8'hA0 + 8'(s))) begin
        bad++;
        $display("FAIL route_out sel=%0d: ovalid=%h data=%h, required %h/%h",
                 s, ovalid, odata[s*8 +: 8], 8'h01 << s, 8'hA0 + 8'(s));
      end
    end
    valid = 1'b0;
    cycle();
    total++;
    if (ovalid !== 8'h00) begin
      bad++;
      $display("FAIL route_drain: ovalid=%h, required 00", ovalid);
    end
  endtask

  task automatic test_backpressure();
    oready = 8'hf7;
    valid = 1'b1; sel = 3'd3; data = 8'h11;
    cycle();
    data = 8'h22;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL bp_ready_stalled: got %b, required 0", ready);
    end
    cycle();
    total++;
    if (ovalid[3] !== 1'b1 || odata[24 +: 8] !== 8'h11) begin
      bad++;
      $display("FAIL bp_hold: valid=%b data=%h, required 1/11", ovalid[3], odata[24 +: 8]);
    end
    // Other channels keep flowing while ch3 is stalled.
    sel = 3'd5; data = 8'h55;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL nonblock_ready: got %b, required 1", ready);
    end
    cycle();
    total++;
    if (ovalid[5] !== 1'b1 || odata[40 +: 8] !== 8'h55 || odata[24 +: 8] !== 8'h11) begin
      bad++;
      $display("FAIL nonblock_out: v5=%b d5=%h d3=%h, required 1/55/11",
               ovalid[5], odata[40 +: 8], odata[24 +: 8]);
    end
    // Release ch3: drain and refill on the same edge.
    sel = 3'd3; data = 8'h22; oready = 8'hff;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL bp_refill_ready: got %b, required 1", ready);
    end
    cycle();
    total++;
    if (ovalid[3] !== 1'b1 || odata[24 +: 8] !== 8'h22) begin
      bad++;
      $display("FAIL bp_refill: valid=%b data=%h, required 1/22", ovalid[3], odata[24 +: 8]);
    end
    valid = 1'b0;
    cycle();
    total++;
    if (ovalid !== 8'h00) begin
      bad++;
      $display("FAIL bp_drain: ovalid=%h, required 00", ovalid);
    end
  endtask

  task automatic test_drop();
    logic [1:0] exp_cnt;
    exp_cnt = 2'd0;
    valid2 = 1'b1; sel2 = 3'd7;
    for (int i = 0; i < 5; i++) begin
      data2 = 8'(i) + 8'hC0;
      #1;
      total++;
      if (ready2 !== 1'b1) begin
        bad++;
        $display("FAIL drop_ready #%0d: got %b, required 1", i, ready2);
      end
      cycle();
      exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
      total++;
      if (drop2 !== exp_cnt || ovalid2 !== 6'h00) begin
        bad++;
        $display("FAIL drop_cnt #%0d: cnt=%0d ovalid=%h, required %0d/00", i, drop2, ovalid2, exp_cnt);
      end
    end
    valid2 = 1'b0;
  endtask

  task automatic test_reset_mid();
    oready = 8'h00;
    valid = 1'b1;
    for (int s = 0; s < 5; s += 2) begin
      sel = 3'(s); data = 8'h30 + 8'(s);
      cycle();
    end
    valid = 1'b0;
    #1;
    total++;
    if (ovalid !== 8'b0001_0101) begin
      bad++;
      $display("FAIL rstmid_fill: ovalid=%h, required 15", ovalid);
    end
    #1;
    rst_n = 1'b0;
    #1;
    total++;
    if (ovalid !== 8'h00 || odata !== 64'h0 || drop2 !== 2'd0) begin
      bad++;
      $display("FAIL rstmid_async: ovalid=%h odata=%h drop2=%0d, required 0/0/0", ovalid, odata, drop2);
    end
    rst_n = 1'b1;
    clear_sb();
    oready = 8'hff;
    @(negedge clk);
  endtask

`ifdef STREAM_DEMUX_BCAST_EN
  task automatic test_bcast();
    logic okd;
    oready = 8'hff;
    valid = 1'b1; bcast = 1'b1; data = 8'h5A; sel = 3'd2;
    #1;
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL bcast_ready: got %b, required 1", ready);
    end
    oready = 8'hfd;
    cycle();
    okd = 1'b1;
    for (int k = 0; k < 8; k++) if (odata[k*8 +: 8] !== 8'h5A) okd = 1'b0;
    total++;
    if (ovalid !== 8'hff || !okd) begin
      bad++;
      $display("FAIL bcast_out: ovalid=%h odata=%h, required ff/all 5A", ovalid, odata);
    end
    data = 8'h6B;
    #1;
    total++;
    if (ready !== 1'b0) begin
      bad++;
      $display("FAIL bcast_stalled_ready: got %b, required 0", ready);
    end
    valid = 1'b0; bcast = 1'b0;
    cycle();
    oready = 8'hff;
    cycle();
  endtask
`endif

  initial begin
    test_reset();
    test_routing();
    test_backpressure();
    test_drop();
    test_reset_mid();
`ifdef STREAM_DEMUX_BCAST_EN
    test_bcast();
`endif
    valid = 1'b0;
    cycle();
    cycle();
    begin
      int left;
      left = 0;
      for (int k = 0; k < 8; k++) left += exp_q[k].size();
      total++;
      if (left != 0) begin
        bad++;
        $display("FAIL sb_leftover: %0d words never delivered, required 0", left);
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_stream_demux_reg

// File: doc/stream_demux_reg.md
Name: stream_demux_reg

Overview:
- Parametrised registered 1-to-N stream demultiplexer, the next generation of the team's combinational 1-to-8 demux.
- Routes a DATA_W-bit word with a select field to one of NUM_OUT output channels.
- Each output channel has a one-entry register slot with valid/ready handshake, so a stalled channel never blocks traffic to other channels.
- Sits between a single producer and NUM_OUT independent consumers.

Parameters:
- DATA_W, 8, payload width in bits.
- NUM_OUT, 8, number of output channels (2..32; need not be a power of two).
- SEL_W, $clog2(NUM_OUT), select field width.
- CNT_W, 8, width of the drop counter.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept the input word.
- in_sel  in  SEL_W  destination channel index.
- in_data  in  DATA_W  payload.
- out_valid  out  NUM_OUT  per-channel slot full.
- out_ready  in  NUM_OUT  per-channel consumer ready.
- out_data  out  NUM_OUT*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W].
- drop_cnt  out  CNT_W  count of words dropped because in_sel >= NUM_OUT.

Behaviour:
- Reset (async assert, sync-safe deassert) drives all slots empty: out_valid=0, out_data=0, drop_cnt=0.
- A transfer occurs on the rising edge where in_valid & in_ready.
- Slot k is "free" when it is empty, or when it is full and out_ready[k]=1 in the same cycle (drain and refill in one cycle).
- in_ready is combinational:
  - 1 if in_sel < NUM_OUT and slot[in_sel] is free.
  - 1 if in_sel >= NUM_OUT (the word is accepted and discarded).
  - 0 otherwise.
- in_ready depends only on in_sel, slot state and out_ready, never on in_valid.
- Latency: a word accepted at edge t appears with out_valid[sel]=1 after edge t, i.e. one cycle.
- A slot holds out_data stable while out_valid=1 and out_ready=0. Consumers may hold out_ready high indefinitely.
- An empty slot's out_data keeps its last value; it is only meaningful when out_valid=1.
- Throughput: one word per cycle when the target slot drains every cycle. Words to different channels never interact.
- Order is preserved per channel. Ordering across channels is not defined.
- Dropped word (in_sel >= NUM_OUT): drop_cnt increments by 1 and saturates at 2^CNT_W-1 (no wrap). No out_valid is asserted.
- Each slot is a two-state FSM:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on out_ready without a load.
  - FULL -> FULL on simultaneous drain and load (data replaced).
- Reset asserted mid-transfer discards all slot contents immediately. No partial handshake survives reset.

Optional Feature:
- Macro: STREAM_DEMUX_BCAST_EN.
- With the macro defined:
  - Port in_bcast (in, 1) is added.
  - When in_bcast=1, in_ready=1 only if all NUM_OUT slots are free. On transfer, every slot loads in_data simultaneously.
  - in_sel is ignored in this case, and drop_cnt is unaffected.
- Without the macro: port absent, unicast behaviour only.

Decomposition:
- Package stream_demux_pkg holds:
  - Default parameter constants.
  - The saturating-increment function.
  - A slot state typedef (EMPTY/FULL).
- Sub-module stream_demux_slot: one-entry register slot with load/drain/valid/ready. The top generates NUM_OUT instances and adds the select decode, in_ready mux and drop counter.

Test Plan:
- Basic routing: DATA_W=8, NUM_OUT=8, all out_ready=1. Send in_sel=0..7 with data 0xA0+sel -> out_valid one-hot, set the cycle after each transfer, out_data[k]=0xA0+k; in_ready stays 1.
- Backpressure: out_ready[3]=0. Send two words to ch3 (0x11, 0x22) -> the first is held at 0x11, in_ready=0 for the second. Set out_ready[3]=1 -> 0x11 is consumed, 0x22 loads the same edge, out_valid[3] stays 1.
- Non-blocking: ch3 stalled and full. Send a word to ch5 -> accepted immediately, out_valid[5]=1 the next cycle.
- Drop/saturation: NUM_OUT=6, CNT_W=2. Send 5 words with in_sel=7 -> no out_valid asserted, drop_cnt reads 1, 2, 3, 3, 3.
- Reset mid-operation: fill slots 0, 2, 4 with out_ready=0, then pulse rst_n low between clock edges -> out_valid=0 and drop_cnt=0 immediately, asynchronously.
- Broadcast (macro defined): all slots empty, in_bcast=1, data 0x5A -> all out_valid=1 and all out_data=0x5A the next cycle. With one slot stalled, a second bcast sees in_ready=0.
